// File: rtl/crc_job_sequencer.sv
// crc_job_sequencer: single-master job controller for the CRC peripheral.
// Accepts one job at a time, programs CTRL/GPOLY/DATA, streams the job's
// data words into DATA, reads the checksum back and returns it on a
// valid/ready result handshake.
`timescale 1ns/1ps
module crc_job_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h4003_2000,
  parameter int          LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_seed,
  input  logic [31:0]      job_poly,
  input  logic [5:0]       job_cfg,
  input  logic [LEN_W-1:0] job_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy,
  output logic [31:0]      crc_addr,
  output logic [31:0]      crc_data_wr,
  output logic             crc_rw,
  output logic             crc_sel,
  input  logic [31:0]      crc_data_rd
);

  localparam logic [31:0] ADDR_DATA  = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] ADDR_GPOLY = BASE_ADDR + 32'h0000_0004;
  localparam logic [31:0] ADDR_CTRL  = BASE_ADDR + 32'h0000_0008;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CFG_SEED = 4'd1,
    S_POLY     = 4'd2,
    S_SEED     = 4'd3,
    S_CFG_RUN  = 4'd4,
    S_DATA     = 4'd5,
    S_RD       = 4'd6,
    S_RCAP     = 4'd7,
    S_RESP     = 4'd8
  } state_t;

  // CTRL layout: {tot, totr, 0, fxor, was, tcrc, 24'b0}; cfg = {tot, totr, fxor, tcrc}
  function automatic logic [31:0] ctrl_word(input logic [5:0] cfg, input logic was);
    return {cfg[5:4], cfg[3:2], 1'b0, cfg[1], was, cfg[0], 24'h00_0000};
  endfunction

  state_t           state_r, state_s;
  logic [31:0]      seed_r, poly_r, res_data_r;
  logic [5:0]       cfg_r;
  logic [LEN_W-1:0] cnt_r;
  logic             sel_s, rw_s;
  logic [31:0]      addr_s, wdata_s;
  logic             accept_s, word_s;

  assign accept_s = (state_r == S_IDLE) && job_valid;
  assign word_s   = (state_r == S_DATA) && in_valid;

  // Next-state logic and combinational decode of the peripheral bus access
  always_comb begin
    state_s = state_r;
    sel_s   = 1'b0;
    rw_s    = 1'b0;
    addr_s  = 32'h0000_0000;
    wdata_s = 32'h0000_0000;
    case (state_r)
      S_IDLE: begin
        if (job_valid) begin
          state_s = S_CFG_SEED;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CFG_SEED: begin
        sel_s   = 1'b1;
        rw_s    = 1'b1;
        addr_s  = ADDR_CTRL;
        wdata_s = ctrl_word(cfg_r, 1'b1);
        state_s = S_POLY;
      end
      S_POLY: begin
        sel_s   = 1'b1;
        rw_s    = 1'b1;
        addr_s  = ADDR_GPOLY;
        wdata_s = poly_r;
        state_s = S_SEED;
      end
      S_SEED: begin
        sel_s   = 1'b1;
        rw_s    = 1'b1;
        addr_s  = ADDR_DATA;
        wdata_s = seed_r;
        state_s = S_CFG_RUN;
      end
      S_CFG_RUN: begin
        sel_s   = 1'b1;
        rw_s    = 1'b1;
        addr_s  = ADDR_CTRL;
        wdata_s = ctrl_word(cfg_r, 1'b0);
        if (cnt_r != {LEN_W{1'b0}}) begin
          state_s = S_DATA;
        end else begin
          state_s = S_RD;
        end
      end
      S_DATA: begin
        if (in_valid) begin
          sel_s   = 1'b1;
          rw_s    = 1'b1;
          addr_s  = ADDR_DATA;
          wdata_s = in_data;
          // last counted word: read back on the very next cycle
          if (cnt_r == LEN_W'(1)) begin
            state_s = S_RD;
          end else begin
            state_s = S_DATA;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_RD: begin
        sel_s   = 1'b1;
        rw_s    = 1'b0;
        addr_s  = ADDR_DATA;
        state_s = S_RCAP;
      end
      S_RCAP: begin
        state_s = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job field latches, loaded on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_r <= 32'h0000_0000;
      poly_r <= 32'h0000_0000;
      cfg_r  <= 6'h00;
    end else if (accept_s) begin
      seed_r <= job_seed;
      poly_r <= job_poly;
      cfg_r  <= job_cfg;
    end
  end

  // Remaining-word counter: load on accept, decrement on each consumed word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= job_len;
    end else if (word_s) begin
      cnt_r <= cnt_r - LEN_W'(1);
    end
  end

  // Result capture: read data arrives the cycle after the read strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data_r <= 32'h0000_0000;
    end else if (state_r == S_RCAP) begin
      res_data_r <= crc_data_rd;
    end
  end

  assign job_ready   = (state_r == S_IDLE);
  assign busy        = (state_r != S_IDLE);
  assign in_ready    = (state_r == S_DATA);
  assign res_valid   = (state_r == S_RESP);
  assign res_data    = res_data_r;
  assign crc_sel     = sel_s;
  assign crc_rw      = rw_s;
  assign crc_addr    = addr_s;
  assign crc_data_wr = wdata_s;

endmodule

// File: tb/tb_crc_job_sequencer.sv
// Testbench for crc_job_sequencer: scoreboard of expected bus accesses and
// results, a small peripheral read model, and per-scenario timing checks.
`timescale 1ns/1ps
module tb_crc_job_sequencer;

  localparam logic [31:0] A_DATA = 32'h4003_2000;
  localparam logic [31:0] A_POLY = 32'h4003_2004;
  localparam logic [31:0] A_CTRL = 32'h4003_2008;

  logic        clk, rst;
  logic        job_valid, job_ready;
  logic [31:0] job_seed, job_poly;
  logic [5:0]  job_cfg;
  logic [15:0] job_len;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        busy;
  logic [31:0] crc_addr, crc_data_wr, crc_data_rd;
  logic        crc_rw, crc_sel;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [64:0] bus_q[$];   // {rw, addr, data}
  logic [31:0] res_q[$];
  logic [31:0] rd_value;
  logic [64:0] mon_b;
  logic [31:0] mon_r;

  crc_job_sequencer #(.BASE_ADDR(32'h4003_2000), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_seed(job_seed), .job_poly(job_poly), .job_cfg(job_cfg), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy),
    .crc_addr(crc_addr), .crc_data_wr(crc_data_wr), .crc_rw(crc_rw), .crc_sel(crc_sel),
    .crc_data_rd(crc_data_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: read data valid the cycle after a read strobe, garbage otherwise
  always @(posedge clk) crc_data_rd <= (crc_sel && !crc_rw) ? rd_value : 32'hDEAD_BEEF;

  // Bus monitor: every strobe must match the next expected access; idle bus is all zero
  always @(negedge clk) begin
    checks = checks + 1;
    if (crc_sel) begin
      if (bus_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL bus_unexpected cyc=%0d got rw=%b addr=%h data=%h, required no access",
                 cyc, crc_rw, crc_addr, crc_data_wr);
      end else begin
        mon_b = bus_q.pop_front();
        if ({crc_rw, crc_addr, crc_data_wr} !== mon_b) begin
          errors = errors + 1;
          $display("FAIL bus_access cyc=%0d got rw=%b addr=%h data=%h, required rw=%b addr=%h data=%h",
                   cyc, crc_rw, crc_addr, crc_data_wr, mon_b[64], mon_b[63:32], mon_b[31:0]);
        end
      end
    end else if ({crc_rw, crc_addr, crc_data_wr} !== 65'd0) begin
      errors = errors + 1;
      $display("FAIL bus_idle_zero cyc=%0d got rw=%b addr=%h data=%h, required all 0",
               cyc, crc_rw, crc_addr, crc_data_wr);
    end
  end

  // Result monitor: each completed result handshake pops the expected checksum
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      checks = checks + 1;
      if (res_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL result_unexpected cyc=%0d got %h, required no result", cyc, res_data);
      end else begin
        mon_r = res_q.pop_front();
        if (res_data !== mon_r) begin
          errors = errors + 1;
          $display("FAIL result_data cyc=%0d got %h, required %h", cyc, res_data, mon_r);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d got no finish, required finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic push_preamble(input logic [31:0] seed, input logic [31:0] poly,
                               input logic [5:0] cfg, input logic [15:0] len);
    bus_q.push_back({1'b1, A_CTRL, cfg[5:4], cfg[3:2], 1'b0, cfg[1], 1'b1, cfg[0], 24'h00_0000});
    bus_q.push_back({1'b1, A_POLY, poly});
    bus_q.push_back({1'b1, A_DATA, seed});
    bus_q.push_back({1'b1, A_CTRL, cfg[5:4], cfg[3:2], 1'b0, cfg[1], 1'b0, cfg[0], 24'h00_0000});
    if (len == 16'd0) bus_q.push_back({1'b0, A_DATA, 32'h0000_0000});
  endtask

  // Offer a job; t_acc = accept cycle or -1. Returns at #1 into T+1.
  task automatic send_job(input logic [31:0] seed, input logic [31:0] poly, input logic [5:0] cfg,
                          input logic [15:0] len, input bit push_pre, input bit hold,
                          output int t_acc);
    @(posedge clk); #1;
    job_seed = seed; job_poly = poly; job_cfg = cfg; job_len = len; job_valid = 1'b1;
    if (push_pre) push_preamble(seed, poly, cfg, len);
    t_acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (job_ready) begin
        t_acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    job_valid = hold;
  endtask

  // Stream n words back-to-back starting in T+5; returns at #1 into T+5+n
  task automatic feed_words(input int n, input int t_acc);
    while (cyc < t_acc + 5) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      bus_q.push_back({1'b1, A_DATA, in_data});
      if (i == n - 1) bus_q.push_back({1'b0, A_DATA, 32'h0000_0000});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic handshake();
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1; rst = 1'b0;
    #2;
    checks = checks + 1;
    if ({job_ready, busy, in_ready, res_valid} !== 4'b1000) begin
      errors = errors + 1;
      $display("FAIL reset_handshakes got rdy/busy/in_rdy/res_v=%b, required 1000",
               {job_ready, busy, in_ready, res_valid});
    end
    checks = checks + 1;
    if ({res_data, crc_sel, crc_rw, crc_addr, crc_data_wr} !== 98'd0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs got res_data=%h sel=%b rw=%b addr=%h wd=%h, required all 0",
               res_data, crc_sel, crc_rw, crc_addr, crc_data_wr);
    end
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if ({crc_sel, busy} !== 2'b00) begin
        errors = errors + 1;
        $display("FAIL idle_quiet i=%0d got sel=%b busy=%b, required 0 0", i, crc_sel, busy);
      end
    end
  endtask

  task automatic test_zero_len();
    int t, tr;
    rd_value = 32'h1234_5678;
    res_q.push_back(32'h1234_5678);
    bus_q.push_back({1'b1, A_CTRL, 32'h0300_0000});
    bus_q.push_back({1'b1, A_POLY, 32'h04C1_1DB7});
    bus_q.push_back({1'b1, A_DATA, 32'hFFFF_FFFF});
    bus_q.push_back({1'b1, A_CTRL, 32'h0100_0000});
    bus_q.push_back({1'b0, A_DATA, 32'h0000_0000});
    send_job(32'hFFFF_FFFF, 32'h04C1_1DB7, 6'b00_00_0_1, 16'd0, 1'b0, 1'b0, t);
    checks = checks + 1;
    if (t < 0) begin
      errors = errors + 1;
      $display("FAIL zl_accept got no accept, required accept");
    end
    for (int i = 0; i < 10 && cyc < t + 5; i++) @(negedge clk);
    checks = checks + 1;
    if ({crc_sel, crc_rw, crc_addr} !== {1'b1, 1'b0, A_DATA}) begin
      errors = errors + 1;
      $display("FAIL zl_read_T5 got sel=%b rw=%b addr=%h, required 1 0 %h", crc_sel, crc_rw, crc_addr, A_DATA);
    end
    wait_res(tr);
    checks = checks + 1;
    if (tr != t + 7) begin
      errors = errors + 1;
      $display("FAIL zl_res_time got T+%0d, required T+7", tr - t);
    end
    handshake();
    @(negedge clk);
    checks = checks + 1;
    if ({job_ready, res_valid} !== 2'b10) begin
      errors = errors + 1;
      $display("FAIL zl_idle got job_ready=%b res_valid=%b, required 1 0", job_ready, res_valid);
    end
  endtask

  task automatic test_gaps();
    int t, tr, rem;
    logic [4:0] pat;
    logic exp_rdy;
    pat = 5'b11101;
    rem = 3;
    rd_value = 32'h0A0B_0C03;
    res_q.push_back(32'h0A0B_0C03);
    send_job(32'h1111_2222, 32'h1EDC_6F41, 6'b10_01_1_0, 16'd3, 1'b1, 1'b0, t);
    checks = checks + 1;
    if (t < 0) begin
      errors = errors + 1;
      $display("FAIL gap_accept got no accept, required accept");
    end
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = pat[i];
      in_data  = $urandom;
      exp_rdy  = (rem > 0);
      if (pat[i] && rem > 0) begin
        bus_q.push_back({1'b1, A_DATA, in_data});
        rem = rem - 1;
        if (rem == 0) bus_q.push_back({1'b0, A_DATA, 32'h0000_0000});
      end
      @(negedge clk);
      checks = checks + 1;
      if (in_ready !== exp_rdy) begin
        errors = errors + 1;
        $display("FAIL gap_in_ready i=%0d got %b, required %b", i, in_ready, exp_rdy);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks = checks + 1;
    if (in_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL gap_unconsumed got in_ready=%b, required 0", in_ready);
    end
    in_valid = 1'b0;
    wait_res(tr);
    checks = checks + 1;
    if (tr != t + 11) begin
      errors = errors + 1;
      $display("FAIL gap_res_time got T+%0d, required T+11", tr - t);
    end
    handshake();
    checks = checks + 1;
    if (bus_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL gap_bus_left got %0d pending accesses, required 0", bus_q.size());
    end
  endtask

  task automatic test_backpressure();
    int t, tr;
    rd_value = 32'hC0DE_0001;
    res_q.push_back(32'hC0DE_0001);
    send_job(32'hAAAA_5555, 32'h8005_0000, 6'b01_10_0_1, 16'd1, 1'b1, 1'b0, t);
    feed_words(1, t);
    wait_res(tr);
    checks = checks + 1;
    if (t < 0 || tr != t + 8) begin
      errors = errors + 1;
      $display("FAIL bp_res_time got accept=%0d res=%0d, required res=accept+8", t, tr);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if ({res_valid, res_data, job_ready, crc_sel} !== {1'b1, 32'hC0DE_0001, 1'b0, 1'b0}) begin
        errors = errors + 1;
        $display("FAIL bp_hold i=%0d got res_v=%b res=%h job_rdy=%b sel=%b, required 1 c0de0001 0 0",
                 i, res_valid, res_data, job_ready, crc_sel);
      end
    end
    handshake();
    @(negedge clk);
    checks = checks + 1;
    if (job_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL bp_release got job_ready=%b, required 1", job_ready);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, tr1, tr2;
    rd_value = 32'hB2B0_0001;
    res_q.push_back(32'hB2B0_0001);
    res_q.push_back(32'hB2B0_0002);
    send_job(32'h0000_0001, 32'h0000_1021, 6'b11_00_1_1, 16'd2, 1'b1, 1'b1, t1);
    job_seed = 32'h0000_0002; job_poly = 32'h0000_8BB7; job_cfg = 6'b00_11_0_0; job_len = 16'd1;
    feed_words(2, t1);
    push_preamble(32'h0000_0002, 32'h0000_8BB7, 6'b00_11_0_0, 16'd1);
    wait_res(tr1);
    checks = checks + 1;
    if (t1 < 0 || tr1 != t1 + 9) begin
      errors = errors + 1;
      $display("FAIL b2b_res1_time got accept=%0d res=%0d, required res=accept+9", t1, tr1);
    end
    rd_value = 32'hB2B0_0002;
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    t2 = -1;
    @(negedge clk);
    if (job_ready && job_valid) t2 = cyc;
    checks = checks + 1;
    if (t2 != tr1 + 2) begin
      errors = errors + 1;
      $display("FAIL b2b_accept2 got cycle %0d, required %0d", t2, tr1 + 2);
    end
    @(posedge clk); #1; job_valid = 1'b0;
    feed_words(1, t2);
    wait_res(tr2);
    checks = checks + 1;
    if (tr2 != t2 + 8) begin
      errors = errors + 1;
      $display("FAIL b2b_res2_time got T+%0d, required T+8", tr2 - t2);
    end
    handshake();
  endtask

  task automatic test_reset_data();
    int t, tr;
    send_job(32'h3333_4444, 32'h04C1_1DB7, 6'b00_00_1_1, 16'd8, 1'b1, 1'b0, t);
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      bus_q.push_back({1'b1, A_DATA, in_data});
      @(posedge clk); #1;
    end
    in_data = 32'h5555_AAAA;
    #1;
    checks = checks + 1;
    if (crc_sel !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL rst_pre_sel got %b, required 1", crc_sel);
    end
    #1; rst = 1'b0;
    #1;
    checks = checks + 1;
    if ({crc_sel, in_ready, busy, job_ready, res_data} !== {4'b0001, 32'h0000_0000}) begin
      errors = errors + 1;
      $display("FAIL rst_async got sel=%b in_rdy=%b busy=%b job_rdy=%b res=%h, required 0 0 0 1 0",
               crc_sel, in_ready, busy, job_ready, res_data);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if (res_valid !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL rst_no_result i=%0d got res_valid=%b, required 0", i, res_valid);
      end
    end
    rd_value = 32'h600D_0001;
    res_q.push_back(32'h600D_0001);
    send_job(32'h7777_8888, 32'h1EDC_6F41, 6'b01_01_0_1, 16'd1, 1'b1, 1'b0, t);
    feed_words(1, t);
    wait_res(tr);
    checks = checks + 1;
    if (t < 0 || tr != t + 8) begin
      errors = errors + 1;
      $display("FAIL rst_fresh_time got accept=%0d res=%0d, required res=accept+8", t, tr);
    end
    handshake();
    checks = checks + 1;
    if (bus_q.size() != 0 || res_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL rst_queues got bus=%0d res=%0d pending, required 0 0", bus_q.size(), res_q.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    job_valid = 1'b0; job_seed = 32'h0; job_poly = 32'h0; job_cfg = 6'h0; job_len = 16'h0;
    in_valid = 1'b0; in_data = 32'h0; res_ready = 1'b0; rd_value = 32'h0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    test_reset();
    test_zero_len();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_reset_data();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
